// File: rtl/bram_port_arbiter_pkg.sv
// Shared encodings for the BRAM port arbiter and the UART memory-access engine.
package bram_port_arbiter_pkg;

    localparam int MEM_ADDR_WIDTH = 13;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] CORE = 2'b01;
    localparam logic [1:0] DBG  = 2'b10;
    localparam logic [1:0] LOCK = 2'b11;

    localparam logic [1:0] RD_NONE = 2'b00;
    localparam logic [1:0] RD_CORE = 2'b01;
    localparam logic [1:0] RD_DBG  = 2'b10;

endpackage

// File: rtl/bram_port_arbiter_arb_read_return.sv
// Tags each granted read with its issuer and steers the 1-cycle BRAM
// read data back to that side, holding it until that side's next return.
module arb_read_return
    import bram_port_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        c_rd,
    input  logic        d_rd,
    input  logic [31:0] mem_dout,
    output logic        c_rvalid,
    output logic [31:0] c_rdata,
    output logic        d_rvalid,
    output logic [31:0] d_rdata
);

    logic [1:0]  rd_owner;
    logic [31:0] c_hold;
    logic [31:0] d_hold;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_owner <= RD_NONE;
            c_hold   <= '0;
            d_hold   <= '0;
        end else begin
            if (c_rd)
                rd_owner <= RD_CORE;
            else if (d_rd)
                rd_owner <= RD_DBG;
            else
                rd_owner <= RD_NONE;
            if (rd_owner == RD_CORE)
                c_hold <= mem_dout;
            if (rd_owner == RD_DBG)
                d_hold <= mem_dout;
        end
    end

    // BRAM data arrives in the return cycle; pass it through, then hold it.
    assign c_rvalid = (rd_owner == RD_CORE);
    assign d_rvalid = (rd_owner == RD_DBG);
    assign c_rdata  = c_rvalid ? mem_dout : c_hold;
    assign d_rdata  = d_rvalid ? mem_dout : d_hold;

endmodule

// File: rtl/bram_port_arbiter.sv
// Core/debug arbiter for one shared 32-bit BRAM port with starvation guard.
// Define ARB_LOCK_EN to add the d_lock exclusive debug ownership mode.
module bram_port_arbiter
    import bram_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = MEM_ADDR_WIDTH,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  c_req,
    input  logic [3:0]            c_we,
    input  logic [ADDR_WIDTH-1:0] c_addr,
    input  logic [31:0]           c_wdata,
    output logic                  c_gnt,
    output logic                  c_rvalid,
    output logic [31:0]           c_rdata,
    input  logic                  d_req,
    input  logic [3:0]            d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [31:0]           d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [31:0]           d_rdata,
`ifdef ARB_LOCK_EN
    input  logic                  d_lock,
`endif
    output logic                  mem_en,
    output logic [3:0]            mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_din,
    input  logic [31:0]           mem_dout
);

    localparam logic [7:0] LIM = 8'(STARVE_LIMIT);

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic [7:0]            streak;
    logic [ADDR_WIDTH-1:0] last_addr;
    logic [31:0]           last_din;
    logic                  starved;
    logic                  core_block;

    assign starved = d_req && (streak == LIM);

`ifdef ARB_LOCK_EN
    assign core_block = (state == LOCK);
`else
    assign core_block = 1'b0;
`endif

    assign c_gnt = c_req && !starved && !core_block;
    assign d_gnt = d_req && !c_gnt;

    assign mem_en   = c_gnt || d_gnt;
    assign mem_we   = c_gnt ? c_we : (d_gnt ? d_we : 4'b0000);
    assign mem_addr = c_gnt ? c_addr : (d_gnt ? d_addr : last_addr);
    assign mem_din  = c_gnt ? c_wdata : (d_gnt ? d_wdata : last_din);

    always_comb begin
        state_nxt = IDLE;
        if (c_gnt)
            state_nxt = CORE;
        else if (d_gnt)
            state_nxt = DBG;
`ifdef ARB_LOCK_EN
        // From CORE, lock only once the core has released the port.
        if (state == LOCK)
            state_nxt = d_lock ? LOCK : IDLE;
        else if (d_lock && (state != CORE || !c_gnt))
            state_nxt = LOCK;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            streak    <= '0;
            last_addr <= '0;
            last_din  <= '0;
        end else begin
            state <= state_nxt;
            if (!d_req || d_gnt)
                streak <= '0;
            else if (c_gnt && streak != LIM)
                streak <= streak + 8'd1;
            if (mem_en) begin
                last_addr <= mem_addr;
                last_din  <= mem_din;
            end
        end
    end

    logic unused_state;
    assign unused_state = ^state;

    arb_read_return u_ret (
        .clk      (clk),
        .rst_n    (rst_n),
        .c_rd     (c_gnt && (c_we == 4'b0000)),
        .d_rd     (d_gnt && (d_we == 4'b0000)),
        .mem_dout (mem_dout),
        .c_rvalid (c_rvalid),
        .c_rdata  (c_rdata),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata)
    );

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter with a write-first BRAM model.
module tb_bram_port_arbiter;

    localparam int AW = 13;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          c_req, d_req;
    logic [3:0]    c_we, d_we;
    logic [AW-1:0] c_addr, d_addr;
    logic [31:0]   c_wdata, d_wdata;
    logic          c_gnt, d_gnt, c_rvalid, d_rvalid;
    logic [31:0]   c_rdata, d_rdata;
    logic          mem_en;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_din;
    logic [31:0]   mem_dout;
`ifdef ARB_LOCK_EN
    logic          d_lock;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bram_port_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .c_req    (c_req),
        .c_we     (c_we),
        .c_addr   (c_addr),
        .c_wdata  (c_wdata),
        .c_gnt    (c_gnt),
        .c_rvalid (c_rvalid),
        .c_rdata  (c_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
`ifdef ARB_LOCK_EN
        .d_lock   (d_lock),
`endif
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_dout (mem_dout)
    );

    // Write-first BRAM, one cycle read latency.
    logic [31:0] bram [0:(1<<AW)-1];
    logic [31:0] w;
    always @(posedge clk) begin
        if (mem_en) begin
            w = bram[mem_addr];
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) w[b*8 +: 8] = mem_din[b*8 +: 8];
            bram[mem_addr] <= w;
            mem_dout <= w;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) bram[i] = '0;
        bram[13'h010]  = 32'hDEADBEEF;
        bram[13'h1FFF] = 32'hAAAAAAAA;
        mem_dout = '0;
        rst_n = 1'b0;
        c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
`ifdef ARB_LOCK_EN
        d_lock = 0;
`endif
        step();
        step();
        @(negedge clk);
        check("rst_c_gnt", {31'b0, c_gnt}, 0);
        check("rst_d_gnt", {31'b0, d_gnt}, 0);
        check("rst_c_rvalid", {31'b0, c_rvalid}, 0);
        check("rst_d_rvalid", {31'b0, d_rvalid}, 0);
        check("rst_c_rdata", c_rdata, 0);
        check("rst_d_rdata", d_rdata, 0);
        check("rst_mem_we", {28'b0, mem_we}, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            @(negedge clk);
            check("idle_mem_en", {31'b0, mem_en}, 0);
        end
        step();

        // Single core read
        c_req = 1; c_we = 0; c_addr = 13'h010;
        @(negedge clk);
        check("cr_gnt", {31'b0, c_gnt}, 1);
        check("cr_mem_en", {31'b0, mem_en}, 1);
        check("cr_mem_addr", {19'b0, mem_addr}, 32'h010);
        step();
        c_req = 0;
        @(negedge clk);
        check("cr_rvalid", {31'b0, c_rvalid}, 1);
        check("cr_rdata", c_rdata, 32'hDEADBEEF);
        check("cr_d_rvalid", {31'b0, d_rvalid}, 0);
        check("cr_hold_addr", {19'b0, mem_addr}, 32'h010);
        check("cr_idle_en", {31'b0, mem_en}, 0);
        step();

        // Debug partial write then read-after-write
        d_req = 1; d_we = 4'b0011; d_addr = 13'h1FFF; d_wdata = 32'h12345678;
        @(negedge clk);
        check("dw_gnt", {31'b0, d_gnt}, 1);
        check("dw_mem_we", {28'b0, mem_we}, 32'h3);
        step();
        d_we = 4'b0000;
        @(negedge clk);
        check("dr_gnt", {31'b0, d_gnt}, 1);
        check("dw_no_rvalid", {31'b0, d_rvalid}, 0);
        step();
        d_req = 0;
        @(negedge clk);
        check("dr_rvalid", {31'b0, d_rvalid}, 1);
        check("dr_rdata", d_rdata, 32'hAAAA5678);
        check("dr_c_rvalid", {31'b0, c_rvalid}, 0);
        check("c_rdata_hold", c_rdata, 32'hDEADBEEF);
        step();

        // Starvation: 8 core grants then one debug grant, repeating
        c_req = 1; c_we = 0; c_addr = 13'h010;
        d_req = 1; d_we = 0; d_addr = 13'h1FFF;
        for (int i = 0; i < 18; i++) begin
            logic dg, pc, pd;
            dg = (i % 9 == 8);
            pc = (i > 0) && ((i - 1) % 9 != 8);
            pd = (i > 0) && ((i - 1) % 9 == 8);
            @(negedge clk);
            check($sformatf("st_c_gnt%0d", i), {31'b0, c_gnt}, {31'b0, !dg});
            check($sformatf("st_d_gnt%0d", i), {31'b0, d_gnt}, {31'b0, dg});
            check($sformatf("st_c_rv%0d", i), {31'b0, c_rvalid}, {31'b0, pc});
            check($sformatf("st_d_rv%0d", i), {31'b0, d_rvalid}, {31'b0, pd});
            if (pc) check($sformatf("st_c_rd%0d", i), c_rdata, 32'hDEADBEEF);
            if (pd) check($sformatf("st_d_rd%0d", i), d_rdata, 32'hAAAA5678);
            step();
        end
        c_req = 0; d_req = 0;
        @(negedge clk);
        check("st_last_d_rv", {31'b0, d_rvalid}, 1);
        check("st_last_d_rd", d_rdata, 32'hAAAA5678);
        step();

        // Reset on the edge right after a granted read
        c_req = 1; c_we = 0; c_addr = 13'h010;
        @(negedge clk);
        check("mr_gnt", {31'b0, c_gnt}, 1);
        rst_n = 0;
        step();
        c_req = 0;
        @(negedge clk);
        check("mr_rvalid0", {31'b0, c_rvalid}, 0);
        check("mr_rdata0", c_rdata, 0);
        step();
        rst_n = 1;
        @(negedge clk);
        check("mr_rvalid1", {31'b0, c_rvalid}, 0);
        step();
        @(negedge clk);
        check("mr_rvalid2", {31'b0, c_rvalid}, 0);
        step();

`ifdef ARB_LOCK_EN
        d_lock = 1;
        step();
        c_req = 1; d_req = 1; c_we = 0; d_we = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check($sformatf("lk_d_gnt%0d", i), {31'b0, d_gnt}, 1);
            check($sformatf("lk_c_gnt%0d", i), {31'b0, c_gnt}, 0);
            step();
        end
        d_lock = 0;
        begin
            logic seen;
            seen = 0;
            for (int i = 0; i < 2 && !seen; i++) begin
                @(negedge clk);
                seen = c_gnt;
                step();
            end
            check("lk_release", {31'b0, seen}, 1);
        end
        c_req = 0; d_req = 0;
        step();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

endmodule
